// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants and trellis helpers for the 4-state Viterbi decoder
package viterbi_pkg;

    localparam int N_STATES     = 4;
    localparam int PM_W_DEF     = 7;
    localparam int INIT_BIG_DEF = 32;

    // ns = {u, s[1]}, so the two predecessors of ns differ only in their LSB
    function automatic logic [1:0] pred(input logic [1:0] ns, input logic k);
        return {ns[0], k};
    endfunction

endpackage

// File: rtl/acs_butterfly.sv
// rtl/acs_butterfly.sv - compare-select for the two next states that share one predecessor pair
module acs_butterfly
    import viterbi_pkg::*;
#(
    parameter int PM_W = PM_W_DEF
) (
    input  logic [PM_W-1:0] lo_c0_i,
    input  logic [PM_W-1:0] lo_c1_i,
    input  logic [PM_W-1:0] hi_c0_i,
    input  logic [PM_W-1:0] hi_c1_i,
    output logic [PM_W-1:0] lo_surv_o,
    output logic [PM_W-1:0] hi_surv_o,
    output logic            lo_dec_o,
    output logic            hi_dec_o
);

    // strict compare: a tie keeps predecessor k=0
    assign lo_dec_o  = (lo_c1_i < lo_c0_i);
    assign hi_dec_o  = (hi_c1_i < hi_c0_i);
    assign lo_surv_o = lo_dec_o ? lo_c1_i : lo_c0_i;
    assign hi_surv_o = hi_dec_o ? hi_c1_i : hi_c0_i;

endmodule

// File: rtl/acs_unit.sv
// rtl/acs_unit.sv - add-compare-select stage with frame restart; optional ACS_NORM_EN metric normalisation
module acs_unit
    import viterbi_pkg::*;
#(
    parameter int PM_W      = PM_W_DEF,
    parameter int FRAME_LEN = 24,
    parameter int INIT_BIG  = INIT_BIG_DEF,
    parameter int NORM_TH   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*PM_W-1:0]    cand_pm,
    output logic [4*PM_W-1:0]    pm_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           dec_out,
    output logic [1:0]           best_state,
    output logic                 out_last
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

`ifdef ACS_NORM_EN
    localparam bit PARAMS_OK = (NORM_TH > 0) && (NORM_TH < 2**PM_W) && (INIT_BIG < 2**PM_W);
`else
    localparam bit PARAMS_OK = (FRAME_LEN*2 + INIT_BIG < 2**PM_W) && (NORM_TH > 0);
`endif

    function automatic logic [PM_W-1:0] init_pm(input logic [1:0] s);
        return (s == 2'd0) ? '0 : PM_W'(INIT_BIG);
    endfunction

    logic [PM_W-1:0]  pm_q   [N_STATES];
    logic [PM_W-1:0]  pm_d   [N_STATES];
    logic [PM_W-1:0]  cand_eff [2*N_STATES];
    logic [PM_W-1:0]  surv   [N_STATES];
    logic [PM_W-1:0]  norm   [N_STATES];
    logic [PM_W-1:0]  best_v;
    logic [1:0]       best_idx;
    logic [3:0]       dec_sel;
    logic [3:0]       dec_q, dec_d;
    logic [1:0]       best_q, best_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, drain, restart;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = valid_q && out_ready;
    assign restart  = drain && last_q;

    // On a restart edge the candidates were built from the old frame's metrics;
    // swap that contribution for the initial metric, keeping the branch metric.
    always_comb begin
        logic [1:0]      p;
        logic [PM_W-1:0] raw;
        p   = '0;
        raw = '0;
        for (int ns = 0; ns < N_STATES; ns++) begin
            for (int k = 0; k < 2; k++) begin
                raw = cand_pm[(2*ns+k)*PM_W +: PM_W];
                p   = pred(2'(ns), 1'(k));
                cand_eff[2*ns+k] = restart ? (raw - pm_q[p] + init_pm(p)) : raw;
            end
        end
    end

    acs_butterfly #(.PM_W(PM_W)) u_bf_even (
        .lo_c0_i   (cand_eff[0]),
        .lo_c1_i   (cand_eff[1]),
        .hi_c0_i   (cand_eff[4]),
        .hi_c1_i   (cand_eff[5]),
        .lo_surv_o (surv[0]),
        .hi_surv_o (surv[2]),
        .lo_dec_o  (dec_sel[0]),
        .hi_dec_o  (dec_sel[2])
    );

    acs_butterfly #(.PM_W(PM_W)) u_bf_odd (
        .lo_c0_i   (cand_eff[2]),
        .lo_c1_i   (cand_eff[3]),
        .hi_c0_i   (cand_eff[6]),
        .hi_c1_i   (cand_eff[7]),
        .lo_surv_o (surv[1]),
        .hi_surv_o (surv[3]),
        .lo_dec_o  (dec_sel[1]),
        .hi_dec_o  (dec_sel[3])
    );

    // Uniform subtraction keeps the ordering, so the argmin is taken before it
    always_comb begin
        best_v   = surv[0];
        best_idx = 2'd0;
        for (int s = 1; s < N_STATES; s++) begin
            if (surv[s] < best_v) begin
                best_v   = surv[s];
                best_idx = 2'(s);
            end
        end
        for (int s = 0; s < N_STATES; s++) begin
            norm[s] = surv[s];
        end
`ifdef ACS_NORM_EN
        if (best_v >= PM_W'(NORM_TH)) begin
            for (int s = 0; s < N_STATES; s++) begin
                norm[s] = surv[s] - PM_W'(NORM_TH);
            end
        end
`endif
    end

    always_comb begin
        for (int s = 0; s < N_STATES; s++) begin
            pm_d[s] = pm_q[s];
        end
        dec_d   = dec_q;
        best_d  = best_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (accept) begin
            for (int s = 0; s < N_STATES; s++) begin
                pm_d[s] = norm[s];
            end
            dec_d   = dec_sel;
            best_d  = best_idx;
            valid_d = 1'b1;
            last_d  = (cnt_q == CNT_W'(FRAME_LEN-1));
            cnt_d   = (cnt_q == CNT_W'(FRAME_LEN-1)) ? '0 : cnt_q + 1'b1;
        end else begin
            if (drain) begin
                valid_d = 1'b0;
            end
            if (restart) begin
                for (int s = 0; s < N_STATES; s++) begin
                    pm_d[s] = init_pm(2'(s));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < N_STATES; s++) begin
                pm_q[s] <= init_pm(2'(s));
            end
            dec_q   <= '0;
            best_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            for (int s = 0; s < N_STATES; s++) begin
                pm_q[s] <= pm_d[s];
            end
            dec_q   <= dec_d;
            best_q  <= best_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        for (int s = 0; s < N_STATES; s++) begin
            pm_out[s*PM_W +: PM_W] = pm_q[s];
        end
    end

    assign out_valid  = valid_q;
    assign dec_out    = dec_q;
    assign best_state = best_q;
    assign out_last   = last_q;

    assert property (@(posedge clk) PARAMS_OK)
        else $error("acs_unit: parameters do not fit the metric width");

endmodule

// File: tb/tb_acs_unit.sv
// tb/tb_acs_unit.sv - self-checking bench for acs_unit (model plus directed literals)
module tb_acs_unit;

    localparam int PM_W      = 7;
    localparam int FRAME_LEN = 24;
    localparam int INIT_BIG  = 32;
    localparam int NORM_TH   = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [55:0] cand_pm = '0;
    logic [27:0] pm_out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  dec_out;
    logic [1:0]  best_state;
    logic        out_last;

    int n_cmp  = 0;
    int n_fail = 0;

    acs_unit #(.PM_W(PM_W), .FRAME_LEN(FRAME_LEN), .INIT_BIG(INIT_BIG), .NORM_TH(NORM_TH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cand_pm    (cand_pm),
        .pm_out     (pm_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dec_out    (dec_out),
        .best_state (best_state),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    // Behavioural model: metrics as plain integers, modulo 2**PM_W
    int m_pm [4] = '{0, INIT_BIG, INIT_BIG, INIT_BIG};
    int m_dec  = 0;
    int m_best = 0;
    int m_valid = 0;
    int m_last = 0;
    int m_cnt  = 0;

    function automatic int init_of(input int s);
        return (s == 0) ? 0 : INIT_BIG;
    endfunction

    function automatic logic [27:0] m_packed();
        logic [27:0] r;
        for (int s = 0; s < 4; s++) r[s*7 +: 7] = 7'(m_pm[s]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int c [2];
        int sv [4];
        int mn, bi;
        bit acc, drn, rs;
        acc = in_valid && (!m_valid || out_ready);
        drn = m_valid && out_ready;
        rs  = drn && m_last;
        if (acc) begin
            m_dec = 0;
            for (int ns = 0; ns < 4; ns++) begin
                for (int k = 0; k < 2; k++) begin
                    int p;
                    p = (ns % 2) * 2 + k;
                    c[k] = int'(cand_pm[(2*ns+k)*7 +: 7]);
                    if (rs) c[k] = (c[k] - m_pm[p] + init_of(p) + 256) % 128;
                end
                if (c[1] < c[0]) begin
                    sv[ns] = c[1];
                    m_dec |= (1 << ns);
                end else begin
                    sv[ns] = c[0];
                end
            end
            mn = sv[0]; bi = 0;
            for (int s = 1; s < 4; s++) if (sv[s] < mn) begin mn = sv[s]; bi = s; end
`ifdef ACS_NORM_EN
            if (mn >= NORM_TH) for (int s = 0; s < 4; s++) sv[s] -= NORM_TH;
`endif
            for (int s = 0; s < 4; s++) m_pm[s] = sv[s];
            m_best  = bi;
            m_valid = 1;
            m_last  = (m_cnt == FRAME_LEN - 1);
            m_cnt   = (m_cnt + 1) % FRAME_LEN;
        end else begin
            if (drn) m_valid = 0;
            if (rs) for (int s = 0; s < 4; s++) m_pm[s] = init_of(s);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < 4; s++) m_pm[s] = init_of(s);
            m_dec = 0; m_best = 0; m_valid = 0; m_last = 0; m_cnt = 0;
        end else begin
            model_step();
        end
        #2;
        chk("pm_out", 32'(pm_out), 32'(m_packed()));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        if (m_valid) begin
            chk("dec_out", 32'(dec_out), 32'(m_dec));
            chk("best_state", 32'(best_state), 32'(m_best));
            chk("out_last", 32'(out_last), 32'(m_last));
        end
    end

    task automatic sym(input logic v, input logic r, input logic [55:0] c);
        @(negedge clk);
        in_valid  = v;
        out_ready = r;
        cand_pm   = c;
        @(posedge clk);
        #3;
    endtask

    // Candidates as PM_calc would produce them from the current metrics
    task automatic mk_cand(output logic [55:0] c, input bit zero_bm);
        int v;
        for (int ns = 0; ns < 4; ns++) begin
            for (int k = 0; k < 2; k++) begin
                v = m_pm[(ns % 2) * 2 + k] + (zero_bm ? 0 : int'($urandom_range(0, 2)));
                c[(2*ns+k)*7 +: 7] = 7'(v);
            end
        end
    endtask

    localparam logic [27:0] PM_INIT = {7'd32, 7'd32, 7'd32, 7'd0};

    initial begin
        logic [55:0] c;
        logic [55:0] c2;
        logic [27:0] exp_pm;
        c2 = {7'd6, 7'd7, 7'd4, 7'd4, 7'd2, 7'd9, 7'd5, 7'd3};

        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk("reset pm_out", 32'(pm_out), 32'(PM_INIT));
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        sym(1'b1, 1'b1, c2);
        chk("t2 pm_out", 32'(pm_out), 32'({7'd6, 7'd4, 7'd2, 7'd3}));
        chk("t2 dec_out", 32'(dec_out), 32'(4'b1010));
        chk("t2 best_state", 32'(best_state), 32'd1);

        mk_cand(c, 1'b0);
        for (int i = 0; i < 2; i++) begin
            sym(1'b1, 1'b0, c);
            chk("t3 stall in_ready", 32'(in_ready), 32'd0);
            chk("t3 frozen pm_out", 32'(pm_out), 32'({7'd6, 7'd4, 7'd2, 7'd3}));
            chk("t3 frozen dec_out", 32'(dec_out), 32'(4'b1010));
        end
        sym(1'b1, 1'b1, c);
        mk_cand(c, 1'b0);
        sym(1'b1, 1'b1, c);
        sym(1'b0, 1'b1, '0);
        chk("t3 drained", 32'(out_valid), 32'd0);

        for (int i = 0; i < 10; i++) begin
            mk_cand(c, 1'b0);
            sym(1'b1, 1'b1, c);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6 rst pm_out", 32'(pm_out), 32'(PM_INIT));
        chk("t6 rst out_valid", 32'(out_valid), 32'd0);
        chk("t6 rst dec_out", 32'(dec_out), 32'd0);
        chk("t6 rst best", 32'(best_state), 32'd0);
        chk("t6 rst last", 32'(out_last), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            mk_cand(c, i == FRAME_LEN);
            sym(1'b1, 1'b1, c);
            chk("t4 out_last", 32'(out_last), 32'((i % FRAME_LEN) == FRAME_LEN - 1));
            if (i == FRAME_LEN) begin
                chk("t4 restart pm_out", 32'(pm_out), 32'({7'd32, 7'd0, 7'd32, 7'd0}));
                chk("t4 restart dec", 32'(dec_out), 32'd0);
            end
        end
        sym(1'b0, 1'b1, '0);
        chk("t4 reload pm_out", 32'(pm_out), 32'(PM_INIT));
        sym(1'b0, 1'b1, '0);
        chk("t4 hold pm_out", 32'(pm_out), 32'(PM_INIT));

        for (int i = 0; i < 8; i++) c[i*7 +: 7] = 7'd70;
        sym(1'b1, 1'b1, c);
`ifdef ACS_NORM_EN
        exp_pm = {7'd6, 7'd6, 7'd6, 7'd6};
`else
        exp_pm = {7'd70, 7'd70, 7'd70, 7'd70};
`endif
        chk("t5 pm_out", 32'(pm_out), 32'(exp_pm));
        chk("t5 best", 32'(best_state), 32'd0);
        sym(1'b0, 1'b1, '0);
        sym(1'b0, 1'b1, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
